// File: rtl/rom_loader.sv
// Byte-stream loader into an async SRAM at 0..LAST_ADDR; optional checksum under ROM_LOADER_CHECKSUM_EN.
// Latency: byte accepted in cycle N -> mem_cs_n low N+1, mem_we_n low N+2, both released N+3.
// Backpressure: dl_ready drops for two cycles per byte (one byte per 3 cycles); stays high once done to drain.
module rom_loader #(
    parameter logic [12:0] LAST_ADDR = 13'h1FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_start,
    input  logic        dl_valid,
    input  logic [7:0]  dl_data,
    output logic        dl_ready,
    output logic [12:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_cs_n,
    output logic        mem_we_n,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] counter, counter_nxt;
    logic [12:0] mem_a_nxt;
    logic [7:0]  mem_dout_nxt;
    logic        cs_n_nxt, we_n_nxt, ready_nxt, busy_nxt, done_nxt, overflow_nxt;
    logic        accept;

    assign accept = dl_valid & dl_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            counter  <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_cs_n <= 1'b1;
            mem_we_n <= 1'b1;
            dl_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            mem_a    <= mem_a_nxt;
            mem_dout <= mem_dout_nxt;
            mem_cs_n <= cs_n_nxt;
            mem_we_n <= we_n_nxt;
            dl_ready <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Outputs are registered, so each state computes the values seen in the following cycle.
    always_comb begin
        state_nxt    = state;
        counter_nxt  = counter;
        mem_a_nxt    = mem_a;
        mem_dout_nxt = mem_dout;
        cs_n_nxt     = 1'b1;
        we_n_nxt     = 1'b1;
        ready_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = done;
        overflow_nxt = overflow;

        if (dl_start) begin
            // Restart wins over everything, including a byte offered this cycle and any write in flight.
            state_nxt    = ST_WAIT;
            counter_nxt  = '0;
            done_nxt     = 1'b0;
            overflow_nxt = 1'b0;
            ready_nxt    = 1'b1;
            busy_nxt     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_WAIT: begin
                    busy_nxt = 1'b1;
                    if (accept) begin
                        state_nxt    = ST_STROBE;
                        mem_a_nxt    = counter;
                        mem_dout_nxt = dl_data;
                        cs_n_nxt     = 1'b0;
                    end else begin
                        ready_nxt = 1'b1;
                    end
                end
                ST_STROBE: begin
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = 1'b0;
                    we_n_nxt  = 1'b0;
                    state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    ready_nxt = 1'b1;
                    // Counter saturates at LAST_ADDR so the address can never wrap.
                    if (counter == LAST_ADDR) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = ST_WAIT;
                        counter_nxt = counter + 13'd1;
                        busy_nxt    = 1'b1;
                    end
                end
                ST_DONE: begin
                    ready_nxt = 1'b1;
                    if (accept) begin
                        overflow_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (dl_start) begin
            sum_q <= 8'h00;
        end else if (state == ST_RELEASE) begin
            sum_q <= sum_q + mem_dout;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a byte-stream model predicts each SRAM write and the status flags.
module tb_rom_loader;

    localparam logic [12:0] LAST = 13'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_start, dl_valid;
    logic [7:0]  dl_data;
    logic        dl_ready;
    logic [12:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_cs_n, mem_we_n, busy, done, overflow;
    logic [7:0]  checksum;

    rom_loader #(.LAST_ADDR(LAST)) dut (
        .clk(clk), .reset(reset), .dl_start(dl_start), .dl_valid(dl_valid),
        .dl_data(dl_data), .dl_ready(dl_ready), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .busy(busy), .done(done),
        .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  d;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    int         we_log[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: the n-th byte accepted after a start goes to address n while n <= LAST.
    int         m_cnt = 0;
    logic [7:0] m_sum = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_started = 1'b0;

    function automatic logic [7:0] exp_sum();
`ifdef ROM_LOADER_CHECKSUM_EN
        return m_sum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_cnt = 0; m_sum = 8'h00; m_ovf = 1'b0; m_started = 1'b0;
        end else if (dl_start) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            m_cnt = 0; m_sum = 8'h00; m_ovf = 1'b0; m_started = 1'b1;
        end else if (dl_valid && dl_ready) begin
            if (m_cnt <= int'(LAST)) begin
                exp_q.push_back('{13'(m_cnt), dl_data, cyc + 2});
                m_sum = m_sum + dl_data;
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    end

    // Monitor: every write-strobe cycle is matched against the oldest predicted write.
    bit          rel_pending = 1'b0;
    logic [12:0] rel_a;
    logic [7:0]  rel_d;
    logic        prev_cs = 1'b1;
    wr_t         mon_e;

    always @(negedge clk) begin
        if (reset) begin
            rel_pending = 1'b0;
            prev_cs = 1'b1;
        end else begin
            if (rel_pending) begin
                chk("release", {mem_cs_n, mem_we_n, mem_a, mem_dout}, {1'b1, 1'b1, rel_a, rel_d});
                rel_pending = 1'b0;
            end
            if (!mem_we_n) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: a=%0d d=%h at cycle %0d, none expected", mem_a, mem_dout, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write{cs_prev,cs,a,d,cyc}", {prev_cs, mem_cs_n, mem_a, mem_dout, 32'(cyc)},
                        {1'b0, 1'b0, mon_e.a, mon_e.d, 32'(mon_e.cyc)});
                end
                rel_pending = 1'b1;
                rel_a = mem_a;
                rel_d = mem_dout;
                we_log.push_back(cyc);
            end
            prev_cs = mem_cs_n;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {dl_ready, busy, done, overflow, mem_cs_n, mem_we_n}, 6'b000011);
        chk({tag, "_data"}, {mem_a, mem_dout, checksum}, 29'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 dl_start = 1'b1;
        @(posedge clk); #1 dl_start = 1'b0;
    endtask

    task automatic stream(input int n, input bit incr, input logic [7:0] base);
        int sent = 0;
        int budget = 0;
        logic [7:0] v = base;
        dl_valid = 1'b1;
        dl_data = v;
        while (sent < n && budget < 20 * n + 40) begin
            @(negedge clk);
            if (dl_valid && dl_ready) begin
                sent++;
                v = incr ? v + 8'd1 : 8'($urandom);
            end
            @(posedge clk); #1 dl_data = v;
            budget++;
        end
        dl_valid = 1'b0;
        if (sent < n) begin
            checks++; errors++;
            $display("FAIL stream_timeout: %0d bytes accepted, %0d required", sent, n);
        end
    endtask

    task automatic status(input string tag);
        dl_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, done, m_started && (m_cnt > int'(LAST)));
        chk({tag, "_busy"}, busy, m_started && (m_cnt <= int'(LAST)));
        chk({tag, "_ready"}, dl_ready, m_started);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_checksum"}, checksum, exp_sum());
        chk({tag, "_idle_strobes"}, {mem_cs_n, mem_we_n}, 2'b11);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int budget;
        bit found;
        reset = 1'b0; dl_start = 1'b0; dl_valid = 1'b0; dl_data = 8'h00;
        #1 reset = 1'b1;
        #2 check_reset_vals("reset_init");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle ignores offered bytes.
        dl_valid = 1'b1; dl_data = 8'h33;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_ignores", {dl_ready, busy}, 2'b00);
        @(posedge clk); #1 dl_valid = 1'b0;

        // Full download with dl_valid held high.
        we_log.delete();
        pulse_start();
        @(negedge clk);
        chk("start_flags", {dl_ready, busy, done, overflow}, 4'b1100);
        @(posedge clk); #1;
        stream(8, 1'b1, 8'h01);
        status("full");
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("full_sum_const", checksum, 8'h24);
`else
        chk("full_sum_const", checksum, 8'h00);
`endif
        chk("we_count", we_log.size(), 8);
        for (int i = 1; i < we_log.size(); i++) chk("we_spacing", we_log[i] - we_log[i-1], 3);

        // Byte offered after done is drained, not written.
        @(posedge clk); #1 dl_valid = 1'b1; dl_data = 8'hFF;
        @(posedge clk); #1 dl_valid = 1'b0;
        status("overflow");

        pulse_start();
        @(negedge clk);
        chk("restart_clears", {done, overflow, checksum}, 10'd0);

        // Abort the write of address 5 while chip select is already low.
        @(posedge clk); #1;
        dl_valid = 1'b1; dl_data = 8'($urandom);
        found = 1'b0;
        budget = 0;
        while (!found && budget < 200) begin
            @(posedge clk); #1;
            if (!mem_cs_n && mem_we_n && mem_a == 13'd5) found = 1'b1;
            else dl_data = 8'($urandom);
            budget++;
        end
        chk("abort_reached_a5", found, 1'b1);
        dl_start = 1'b1;
        @(posedge clk); #1 dl_start = 1'b0; dl_valid = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {mem_cs_n, mem_we_n}, 2'b11);
        chk("abort_sum", checksum, 8'h00);
        @(posedge clk); #1;
        stream(8, 1'b0, 8'($urandom));
        status("abort");

        // Randomised traffic with occasional restarts and overflow bytes.
        pulse_start();
        repeat (1500) begin
            @(posedge clk); #1;
            dl_start = ($urandom_range(0, 119) == 0);
            dl_valid = ($urandom_range(0, 2) != 0);
            dl_data  = 8'($urandom);
        end
        dl_start = 1'b0;
        status("random");

        // Asynchronous reset during the write strobe of byte A5.
        pulse_start();
        dl_valid = 1'b1; dl_data = 8'hA5;
        found = 1'b0;
        budget = 0;
        while (!found && budget < 30) begin
            @(negedge clk);
            if (!mem_we_n) found = 1'b1;
            budget++;
        end
        chk("a5_strobe_seen", found, 1'b1);
        #2 reset = 1'b1; dl_valid = 1'b0;
        #1 check_reset_vals("reset_async");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_after");

        chk("writes_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
